// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory bus controller: access sizes, FSM states,
// byte-lane mask, alignment check and load extension.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = 4'b0011 << off;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Size code 3 is reserved and is reported like a misaligned access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [1:0] size, input logic sign);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: extend_load = sign ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
            SZ_HALF: extend_load = sign ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            SZ_WORD: extend_load = sh;
            default: extend_load = 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arb.sv
// Request arbiter: N_PORTS request vector to one-hot grant.
// Define MEM_BUS_RR_EN for round-robin; otherwise fixed priority, lowest index wins.
module mem_bus_arb #(
    parameter int N_PORTS = 2
) (
`ifdef MEM_BUS_RR_EN
    input  logic               clock,
    input  logic               reset,
`endif
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] gnt
);

    logic [N_PORTS-1:0] gnt_s;
    logic               found_s;

`ifdef MEM_BUS_RR_EN
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] nxt_ptr_s;

    // Round-robin search starting at the pointer; the port after the winner becomes the next start.
    always_comb begin
        gnt_s     = '0;
        found_s   = 1'b0;
        nxt_ptr_s = ptr_r;
        for (int k = 0; k < N_PORTS; k++) begin
            if (req[(int'(ptr_r) + k) % N_PORTS] && !found_s) begin
                gnt_s[(int'(ptr_r) + k) % N_PORTS] = 1'b1;
                found_s   = 1'b1;
                nxt_ptr_s = PTR_W'((int'(ptr_r) + k + 1) % N_PORTS);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Search pointer advances only when a grant is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= nxt_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: the first requesting port from index 0 upwards wins.
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (req[k] && !found_s) begin
                gnt_s[k] = 1'b1;
                found_s  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
`endif

    assign gnt = gnt_s;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shared-memory bus controller: arbitrates N requesters onto one single-ported RAM,
// aligns byte lanes and extends loads. MEM_BUS_RR_EN selects round-robin arbitration.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_PORTS-1:0]              req_valid,
    output logic [N_PORTS-1:0]              req_ready,
    input  logic [N_PORTS-1:0]              req_wen,
    input  logic [N_PORTS-1:0][1:0]         req_size,
    input  logic [N_PORTS-1:0]              req_sign,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_PORTS-1:0][31:0]        req_wdata,
    output logic [N_PORTS-1:0]              resp_valid,
    output logic                            resp_err,
    output logic [31:0]                     resp_rdata,
    output logic                            mem_en,
    output logic                            mem_wen,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [31:0]                     mem_wdata,
    output logic [3:0]                      mem_wbmask,
    input  logic [31:0]                     mem_rdata
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    state_e              state_r, state_nx_s;
    logic [N_PORTS-1:0]  req_act_s, grant_s;
    logic                any_s, mis_s;
    logic                sel_wen_s, sel_sign_s;
    logic [1:0]          sel_size_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [31:0]         sel_wdata_s;

    logic [N_PORTS-1:0]  grant_r;
    logic                wen_r, sign_r;
    logic [1:0]          size_r, off_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                mem_en_r, mem_wen_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic [3:0]          mem_wbmask_r;
    logic [N_PORTS-1:0]  resp_valid_r;
    logic                resp_err_r;
    logic [31:0]         resp_rdata_r;

    // Requests are only offered to the arbiter while idle, so the grant doubles as req_ready.
    assign req_act_s = (state_r == ST_IDLE) ? req_valid : '0;
    assign any_s     = |grant_s;
    assign req_ready = grant_s;

    mem_bus_arb #(.N_PORTS(N_PORTS)) u_arb (
`ifdef MEM_BUS_RR_EN
        .clock (clock),
        .reset (reset),
`endif
        .req   (req_act_s),
        .gnt   (grant_s)
    );

    // One-hot mux of the granted port's request fields.
    always_comb begin
        sel_wen_s   = 1'b0;
        sel_sign_s  = 1'b0;
        sel_size_s  = 2'b00;
        sel_addr_s  = '0;
        sel_wdata_s = 32'h00000000;
        for (int i = 0; i < N_PORTS; i++) begin
            sel_wen_s   = sel_wen_s   | (req_wen[i]   & grant_s[i]);
            sel_sign_s  = sel_sign_s  | (req_sign[i]  & grant_s[i]);
            sel_size_s  = sel_size_s  | (req_size[i]  & {2{grant_s[i]}});
            sel_addr_s  = sel_addr_s  | (req_addr[i]  & {ADDR_W{grant_s[i]}});
            sel_wdata_s = sel_wdata_s | (req_wdata[i] & {32{grant_s[i]}});
        end
    end

    assign mis_s = misaligned(sel_size_s, sel_addr_s[1:0]);

    // Next-state logic; misaligned requests skip the RAM and respond directly.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_nx_s = mis_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nx_s = wen_r ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Capture the accepted request; later changes on the requester side are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_r <= '0;
            wen_r   <= 1'b0;
            sign_r  <= 1'b0;
            size_r  <= 2'b00;
            off_r   <= 2'b00;
        end else if (state_r == ST_IDLE && any_s) begin
            grant_r <= grant_s;
            wen_r   <= sel_wen_s;
            sign_r  <= sel_sign_s;
            size_r  <= sel_size_s;
            off_r   <= sel_addr_s[1:0];
        end else begin
            grant_r <= grant_r;
            wen_r   <= wen_r;
            sign_r  <= sign_r;
            size_r  <= size_r;
            off_r   <= off_r;
        end
    end

    // Read-latency down-counter: loaded during ISSUE, read data sampled when it reaches one.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_W'(RD_LATENCY);
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // RAM command registers, live only during the single ISSUE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_en_r     <= 1'b0;
            mem_wen_r    <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h00000000;
            mem_wbmask_r <= 4'b0000;
        end else if (state_r == ST_IDLE && state_nx_s == ST_ISSUE) begin
            mem_en_r     <= 1'b1;
            mem_wen_r    <= sel_wen_s;
            mem_addr_r   <= {sel_addr_s[ADDR_W-1:2], 2'b00};
            mem_wdata_r  <= sel_wen_s ? (sel_wdata_s << {sel_addr_s[1:0], 3'b000}) : 32'h00000000;
            mem_wbmask_r <= sel_wen_s ? lane_mask(sel_size_s, sel_addr_s[1:0]) : 4'b0000;
        end else begin
            mem_en_r     <= 1'b0;
            mem_wen_r    <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h00000000;
            mem_wbmask_r <= 4'b0000;
        end
    end

    // Response registers, high for exactly the RESP cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_r <= '0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h00000000;
        end else if (state_nx_s == ST_RESP) begin
            resp_valid_r <= (state_r == ST_IDLE) ? grant_s : grant_r;
            resp_err_r   <= (state_r == ST_IDLE);
            resp_rdata_r <= (state_r == ST_WAIT) ? extend_load(mem_rdata, off_r, size_r, sign_r)
                                                 : 32'h00000000;
        end else begin
            resp_valid_r <= '0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h00000000;
        end
    end

    assign mem_en     = mem_en_r;
    assign mem_wen    = mem_wen_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wbmask = mem_wbmask_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed steps plus random traffic against a byte-level memory model.
// Arbitration expectations follow MEM_BUS_RR_EN when it is defined.
module tb_mem_bus_ctrl;

    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid, req_ready, req_wen, req_sign, resp_valid;
    logic [1:0][1:0]   req_size;
    logic [1:0][31:0]  req_addr, req_wdata;
    logic              resp_err, mem_en, mem_wen;
    logic [31:0]       resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]        mem_wbmask;

    logic [31:0]       ram [256];
    logic [31:0]       rd_pipe [LAT];
    logic [7:0]        gmem [1024];
    int                rr_ptr;
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.N_PORTS(2), .ADDR_W(32), .RD_LATENCY(LAT)) dut (
        .clock(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wbmask(mem_wbmask), .mem_rdata(mem_rdata)
    );

    // RAM: byte-masked writes, read data appears LAT cycles after the strobe, junk otherwise.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[8'h80] = 32'h80FF7F01;
        forever begin
            @(posedge clk);
            if (mem_en && mem_wen)
                for (int j = 0; j < 4; j++)
                    if (mem_wbmask[j]) ram[mem_addr[9:2]][8*j +: 8] = mem_wdata[8*j +: 8];
            rd_pipe[0] <= (mem_en && !mem_wen) ? ram[mem_addr[9:2]] : $urandom;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_grant(input logic [1:0] v);
`ifdef MEM_BUS_RR_EN
        for (int k = 0; k < 2; k++)
            if (v[(rr_ptr + k) % 2]) return 2'b01 << ((rr_ptr + k) % 2);
`else
        for (int p = 0; p < 2; p++)
            if (v[p]) return 2'b01 << p;
`endif
        return 2'b00;
    endfunction

    function automatic void note_grant(input logic [1:0] g);
        if (g[0]) rr_ptr = 1;
        else if (g[1]) rr_ptr = 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n = 1 << sz;
        int ai = int'(a % 1024);
        logic [31:0] v = 32'h0;
        for (int j = 0; j < n; j++) v = v | (32'(gmem[(ai + j) % 1024]) << (8 * j));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    // Precondition: at a falling edge with the controller idle. Ends at the next idle falling edge.
    task automatic txn(input int p, input logic wen, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [1:0] g;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0] exp_m;
        bit mis;
        int lat, seen, en_cnt, n, off;
        req_wen[p] = wen; req_size[p] = sz; req_sign[p] = sg; req_addr[p] = a; req_wdata[p] = wd;
        req_valid = 2'b00; req_valid[p] = 1'b1;
        #1;
        g = exp_grant(req_valid);
        chk("ready", req_ready, g);
        note_grant(g);
        mis = model_mis(a, sz);
        lat = mis ? 1 : (wen ? 2 : 2 + LAT);
        exp_rd = (mis || wen) ? 32'h0 : model_load(a, sz, sg);
        n = 1 << sz; off = int'(a % 4);
        exp_m = 4'b0000;
        exp_wd = wd << (8 * off);
        if (!mis) for (int j = 0; j < n; j++) exp_m[off + j] = 1'b1;
        if (wen && !mis) for (int j = 0; j < n; j++) gmem[(int'(a % 1024) + j) % 1024] = wd[8*j +: 8];
        seen = 0; en_cnt = 0;
        for (int k = 1; k <= 12 && seen == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 2'b00;
                req_addr[p] = $urandom; req_wdata[p] = $urandom; req_size[p] = 2'($urandom);
            end
            if (mem_en) en_cnt++;
            if (k == 1 && !mis) begin
                chk("mem_en", mem_en, 1);
                chk("mem_wen", mem_wen, wen);
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_wbmask", mem_wbmask, wen ? exp_m : 4'b0000);
                if (wen) chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (resp_valid !== 2'b00) begin
                seen = k;
                chk("resp_valid", resp_valid, g);
                chk("resp_err", resp_err, mis);
                chk("resp_rdata", resp_rdata, exp_rd);
            end
        end
        chk("latency", seen, lat);
        chk("mem_en_count", en_cnt, mis ? 0 : 1);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] g;
        int seen;
        rst = 1'b1; req_valid = 2'b00; req_wen = 2'b00; req_sign = 2'b00;
        req_size = '0; req_addr = '0; req_wdata = '0; rr_ptr = 0;

        // Reset held three cycles with no requests: everything quiet.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_mem_en", mem_en, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) gmem[i] = ram[i / 4][8*(i % 4) +: 8];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_mem_en", mem_en, 0);
            chk("idle_wen_mask", {mem_wen, mem_wbmask}, 0);
            chk("idle_resp", {resp_err, resp_rdata}, 0);
        end

        // Directed: byte store with lane shift, then loads from the known word at 0x200.
        txn(1, 1'b1, 2'd0, 1'b0, 32'h103, 32'hAB);
        txn(0, 1'b0, 2'd0, 1'b1, 32'h202, 32'h0);
        chk("lb_sign_value", model_load(32'h202, 2'd0, 1'b1), 32'hFFFFFFFF);
        txn(1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0);
        txn(0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        txn(1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        txn(0, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
        txn(1, 1'b1, 2'd3, 1'b0, 32'h104, 32'h12345678);

        // Reset during WAIT: request is dropped, then a fresh request works.
        req_wen[0] = 1'b0; req_size[0] = 2'd2; req_sign[0] = 1'b0; req_addr[0] = 32'h200;
        req_valid = 2'b01;
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; rr_ptr = 0;
        for (int k = 0; k < 6; k++) begin
            chk("abort_resp_valid", resp_valid, 0);
            chk("abort_mem_en", mem_en, 0);
            @(negedge clk);
        end
        txn(1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        rr_ptr = 0;
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);

        // Both ports requesting continuously for four back-to-back grants.
        req_wen = 2'b00; req_sign = 2'b00; req_size[0] = 2'd2; req_size[1] = 2'd2;
        req_addr[0] = 32'h0; req_addr[1] = 32'h4;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1;
            g = exp_grant(2'b11);
            chk("arb_ready", req_ready, g);
            note_grant(g);
            seen = 0;
            for (int k = 1; k <= 12 && seen == 0; k++) begin
                @(negedge clk);
                if (resp_valid !== 2'b00) begin
                    seen = k;
                    chk("arb_resp_valid", resp_valid, g);
                    chk("arb_rdata", resp_rdata, model_load(g[0] ? 32'h0 : 32'h4, 2'd2, 1'b0));
                end
            end
            chk("arb_latency", seen, 2 + LAT);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            txn(int'($urandom % 2), 1'($urandom), ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3),
                1'($urandom), $urandom % 1024, $urandom);
            repeat ($urandom % 3) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
